// File: rtl/keypad_scan_arbiter_pkg.sv
// Shared constants and helpers for the keypad scanner / pong step arbiter.
package pong_pkg;

  // One-cold row drive values, in scan order.
  localparam logic [3:0] ROW_0 = 4'b1110;
  localparam logic [3:0] ROW_1 = 4'b1101;
  localparam logic [3:0] ROW_2 = 4'b1011;
  localparam logic [3:0] ROW_3 = 4'b0111;

  // Snapshot bit positions {row index, col index} of the mapped keys.
  localparam logic [3:0] KEY_7 = 4'd0;
  localparam logic [3:0] KEY_0 = 4'd3;
  localparam logic [3:0] KEY_8 = 4'd4;
  localparam logic [3:0] KEY_A = 4'd7;

  localparam int DEB_SCANS_DEF = 3;
  localparam int RPT_SCANS_DEF = 5;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } row_sel_t;

  // Row walker: any illegal drive value recovers to the first row.
  function automatic logic [3:0] next_row(input logic [3:0] row);
    case (row)
      ROW_0:   return ROW_1;
      ROW_1:   return ROW_2;
      ROW_2:   return ROW_3;
      default: return ROW_0;
    endcase
  endfunction

  // Maps the current row drive to its snapshot row index.
  function automatic row_sel_t row_decode(input logic [3:0] row);
    row_sel_t sel;
    sel = '{valid: 1'b1, idx: 2'd0};
    case (row)
      ROW_0:   sel.idx = 2'd0;
      ROW_1:   sel.idx = 2'd1;
      ROW_2:   sel.idx = 2'd2;
      ROW_3:   sel.idx = 2'd3;
      default: sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/keypad_scan_arbiter_if.sv
// Keypad and player-step signals between the arbiter and its surroundings.
interface keypad_scan_arbiter_if;
  logic [3:0] kp_col;
  logic [3:0] kp_row;
  logic       up1;
  logic       down1;
  logic       up2;
  logic       down2;
  logic       scan_done;

  modport master (
    input  kp_col,
    output kp_row, up1, down1, up2, down2, scan_done
  );

  modport slave (
    output kp_col,
    input  kp_row, up1, down1, up2, down2, scan_done
  );
endinterface

// File: rtl/keypad_scan_arbiter_kp_debounce.sv
// Per-key debouncer: evaluated once per completed scan, flips after
// DEB_SCANS consecutive disagreeing scans. Edges are valid with strobe_i.
module kp_debounce
  import pong_pkg::*;
#(
  parameter int DEB_SCANS = DEB_SCANS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,     // 1 = pressed in the latest snapshot
  input  logic strobe_i,  // scan complete
  output logic state_o,   // 1 = debounced pressed
  output logic press_o,
  output logic release_o
);

  logic       state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       flip;

  // Next debounce state and disagreement count.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (strobe_i) begin
      if (raw_i == state_q) begin
        cnt_d = '0;
      end else if (int'(cnt_q) + 1 >= DEB_SCANS) begin
        flip    = 1'b1;
        state_d = raw_i;
        cnt_d   = '0;
      end else if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    if (rst) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = flip & raw_i;
  assign release_o = flip & ~raw_i;

endmodule

// File: rtl/keypad_scan_arbiter.sv
// Scans a 4x4 keypad, debounces the four pong keys and issues per-player
// up/down step pulses with auto-repeat and up+down conflict suppression.
module keypad_scan_arbiter
  import pong_pkg::*;
#(
  parameter int DEB_SCANS = DEB_SCANS_DEF,
  parameter int RPT_SCANS = RPT_SCANS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  keypad_scan_arbiter_if.master  bus
);

  logic [3:0]       kp_row_q, kp_row_d;
  logic [15:0]      snap_q, snap_d;
  logic             scan_done_q, scan_done_d;
  row_sel_t         sel;

  // Key slots: 0 = A (p1 up), 1 = 0 (p1 down), 2 = 8 (p2 up), 3 = 7 (p2 down).
  logic [3:0]       key_raw, key_state, key_press, key_rel, key_next;
  logic [1:0]       up_next, dn_next, up_press, dn_press, up_cur, dn_cur;
  logic [1:0][3:0]  rpt_q, rpt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       up_q, up_d, dn_q, dn_d;
  logic [1:0]       step;
  logic             unused_snap;

  // Row walker, column capture and end-of-scan marker.
  always_comb begin
    sel         = row_decode(kp_row_q);
    kp_row_d    = next_row(kp_row_q);
    snap_d      = snap_q;
    if (sel.valid) snap_d[{sel.idx, 2'b00} +: 4] = bus.kp_col;
    scan_done_d = (kp_row_q == ROW_3);
  end

  // Scan registers; reset restarts at the first row with an all-released snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_row_q    <= ROW_0;
      snap_q      <= 16'hFFFF;
      scan_done_q <= 1'b0;
    end else begin
      kp_row_q    <= kp_row_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
    end
  end

  // Columns are active-low; unmapped keys are captured but ignored.
  assign key_raw     = ~{snap_q[KEY_7], snap_q[KEY_8], snap_q[KEY_0], snap_q[KEY_A]};
  assign unused_snap = ^snap_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    kp_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (key_raw[k]),
      .strobe_i  (scan_done_q),
      .state_o   (key_state[k]),
      .press_o   (key_press[k]),
      .release_o (key_rel[k])
    );
  end

  // Debounced state as it will be after this scan completion.
  assign key_next = (key_state | key_press) & ~key_rel;
  assign up_next  = {key_next[2],  key_next[0]};
  assign dn_next  = {key_next[3],  key_next[1]};
  assign up_press = {key_press[2], key_press[0]};
  assign dn_press = {key_press[3], key_press[1]};
  assign up_cur   = {key_state[2], key_state[0]};
  assign dn_cur   = {key_state[3], key_state[1]};

  // Per-player step arbitration: press, repeat, and conflict hand-over.
  always_comb begin
    rpt_d  = rpt_q;
    pend_d = pend_q;
    step   = '0;
    up_d   = '0;
    dn_d   = '0;
    for (int p = 0; p < 2; p++) begin
      if (scan_done_q) begin
        if (up_next[p] && dn_next[p]) begin
          rpt_d[p]  = '0;
          pend_d[p] = 1'b1;
        end else if (up_next[p] || dn_next[p]) begin
          if (up_press[p] || dn_press[p]) begin
            step[p]   = 1'b1;
            rpt_d[p]  = '0;
            pend_d[p] = 1'b0;
          end else if (up_cur[p] && dn_cur[p]) begin
            rpt_d[p]  = '0;   // conflict just cleared; step on the next scan
          end else if (pend_q[p]) begin
            step[p]   = 1'b1;
            rpt_d[p]  = '0;
            pend_d[p] = 1'b0;
          end else if (int'(rpt_q[p]) + 1 >= RPT_SCANS) begin
            step[p]   = 1'b1;
            rpt_d[p]  = '0;
          end else if (rpt_q[p] != 4'hF) begin
            rpt_d[p]  = rpt_q[p] + 4'd1;
          end
          up_d[p] = step[p] & up_next[p];
          dn_d[p] = step[p] & dn_next[p];
        end else begin
          rpt_d[p]  = '0;
          pend_d[p] = 1'b0;
        end
      end
    end
  end

  // Player arbitration and step output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q  <= '0;
      pend_q <= '0;
      up_q   <= '0;
      dn_q   <= '0;
    end else begin
      rpt_q  <= rpt_d;
      pend_q <= pend_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
    end
  end

  assign bus.kp_row    = kp_row_q;
  assign bus.scan_done = scan_done_q;
  assign bus.up1       = up_q[0];
  assign bus.down1     = dn_q[0];
  assign bus.up2       = up_q[1];
  assign bus.down2     = dn_q[1];

endmodule

// File: tb/tb_keypad_scan_arbiter.sv
// Scoreboard bench: each scenario queues the step pulses it expects (scan
// index + output mask); a negedge monitor pops and compares every pulse and
// checks the scan_done period.
module tb_keypad_scan_arbiter;

  localparam int K_7 = 0;
  localparam int K_0 = 3;
  localparam int K_8 = 4;
  localparam int K_A = 7;
  localparam int K_9 = 8;

  localparam logic [3:0] M_UP1 = 4'b1000;
  localparam logic [3:0] M_DN1 = 4'b0100;
  localparam logic [3:0] M_UP2 = 4'b0010;
  localparam logic [3:0] M_DN2 = 4'b0001;

  typedef struct {
    int         sd;
    logic [3:0] mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;   // 1 = physically pressed, index {row, col}
  logic [3:0]  col;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sd_cnt   = 0;
  int   gap      = 0;
  bit   sd_seen  = 1'b0;
  bit   prev_sd  = 1'b0;

  keypad_scan_arbiter_if bus ();

  keypad_scan_arbiter #(.DEB_SCANS(3), .RPT_SCANS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keypad model: the driven row pulls low the columns of pressed keys.
  always_comb begin
    col = 4'hF;
    case (bus.kp_row)
      4'b1110: col = ~keys[3:0];
      4'b1101: col = ~keys[7:4];
      4'b1011: col = ~keys[11:8];
      4'b0111: col = ~keys[15:12];
      default: col = 4'hF;
    endcase
  end
  assign bus.kp_col = col;

  // Monitor: scoreboard pops on every step pulse, scan_done period check.
  always @(negedge clk) begin
    logic [3:0] got;
    exp_t       e;
    if (rst) begin
      sd_cnt  = 0;
      gap     = 0;
      sd_seen = 1'b0;
      prev_sd = 1'b0;
    end else begin
      gap++;
      got = {bus.up1, bus.down1, bus.up2, bus.down2};
      if (got != 4'b0000) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse: got mask %b after scan %0d, expected none", got, sd_cnt);
        end else begin
          e = exp_q.pop_front();
          if (!prev_sd || e.sd != sd_cnt || e.mask !== got)
            $display("FAIL pulse: got mask %b after scan %0d (follows scan_done=%0d), expected mask %b after scan %0d",
                     got, sd_cnt, prev_sd, e.mask, e.sd);
          else
            n_pass++;
        end
      end
      if (bus.scan_done) begin
        if (sd_seen) begin
          n_checks++;
          if (gap != 4) $display("FAIL scan_period: got %0d clk, expected 4", gap);
          else          n_pass++;
        end
        sd_seen = 1'b1;
        gap     = 0;
        sd_cnt++;
      end
      prev_sd = bus.scan_done;
    end
  end

  function automatic void expect_pulse(input int sd, input logic [3:0] mask);
    exp_t e;
    e.sd   = sd;
    e.mask = mask;
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_sd(input int n);
    int budget;
    budget = (n - sd_cnt) * 4 + 16;
    while (sd_cnt < n && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (sd_cnt < n) begin
      n_checks++;
      $display("FAIL wait_sd: reached scan %0d, expected scan %0d", sd_cnt, n);
    end
  endtask

  task automatic end_scenario(input string name);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_missing: got %0d pulses still outstanding, expected 0", name, exp_q.size());
    else
      n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.kp_row !== 4'b1110) $display("FAIL reset_row: got %b, expected 1110", bus.kp_row);
    else n_pass++;
    n_checks++;
    if ({bus.up1, bus.down1, bus.up2, bus.down2} !== 4'b0000)
      $display("FAIL reset_steps: got %b, expected 0000", {bus.up1, bus.down1, bus.up2, bus.down2});
    else n_pass++;
    n_checks++;
    if (bus.scan_done !== 1'b0) $display("FAIL reset_scan_done: got %b, expected 0", bus.scan_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.kp_row !== 4'b1110) $display("FAIL reset_row_held: got %b, expected 1110", bus.kp_row);
    else n_pass++;
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.kp_row !== 4'b1101) $display("FAIL first_step: got %b, expected 1101", bus.kp_row);
    else n_pass++;
  endtask

  task automatic test_hold_repeat();
    keys = '0;
    keys[K_A] = 1'b1;
    do_reset();
    expect_pulse(3, M_UP1);
    expect_pulse(8, M_UP1);
    expect_pulse(13, M_UP1);
    expect_pulse(18, M_UP1);
    wait_sd(20);
    keys = '0;            // release lands on the scan a repeat would fire
    wait_sd(26);
    end_scenario("hold_repeat");
  endtask

  task automatic test_short_press();
    keys = '0;
    keys[K_A] = 1'b1;
    do_reset();
    wait_sd(2);
    keys = '0;
    wait_sd(8);
    end_scenario("short_press");
  endtask

  task automatic test_overlap();
    keys = '0;
    keys[K_A] = 1'b1;
    keys[K_0] = 1'b1;
    do_reset();
    expect_pulse(14, M_UP1);
    expect_pulse(19, M_UP1);
    expect_pulse(24, M_UP1);
    wait_sd(10);
    keys[K_0] = 1'b0;
    wait_sd(25);
    keys = '0;
    wait_sd(30);
    end_scenario("overlap");
  endtask

  task automatic test_two_players();
    keys = '0;
    keys[K_A] = 1'b1;
    keys[K_8] = 1'b1;
    do_reset();
    expect_pulse(3, M_UP1 | M_UP2);
    expect_pulse(8, M_UP1 | M_UP2);
    expect_pulse(13, M_UP1 | M_UP2);
    wait_sd(14);
    keys = '0;
    wait_sd(20);
    end_scenario("two_players");
  endtask

  task automatic test_down_keys();
    keys = '0;
    keys[K_0] = 1'b1;
    keys[K_7] = 1'b1;
    do_reset();
    expect_pulse(3, M_DN1 | M_DN2);
    expect_pulse(8, M_DN1 | M_DN2);
    wait_sd(9);
    keys = '0;
    wait_sd(14);
    end_scenario("down_keys");
  endtask

  task automatic test_reset_mid_scan();
    int budget;
    keys = '0;
    keys[K_A] = 1'b1;
    do_reset();
    expect_pulse(3, M_UP1);
    wait_sd(5);
    end_scenario("pre_mid_reset");
    budget = 8;
    while (bus.kp_row !== 4'b1011 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    n_checks++;
    if (bus.kp_row !== 4'b1011) $display("FAIL mid_reset_row_wait: got %b, expected 1011", bus.kp_row);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.kp_row !== 4'b1110) $display("FAIL mid_reset_row: got %b, expected 1110", bus.kp_row);
    else n_pass++;
    n_checks++;
    if ({bus.up1, bus.down1, bus.up2, bus.down2, bus.scan_done} !== 5'b00000)
      $display("FAIL mid_reset_outputs: got %b, expected 00000",
               {bus.up1, bus.down1, bus.up2, bus.down2, bus.scan_done});
    else n_pass++;
    @(negedge clk);
    #1 rst = 1'b0;
    expect_pulse(3, M_UP1);
    expect_pulse(8, M_UP1);
    wait_sd(9);
    keys = '0;
    wait_sd(14);
    end_scenario("reset_mid_scan");
  endtask

  task automatic test_ignored_key();
    keys = '0;
    keys[K_9] = 1'b1;
    do_reset();
    wait_sd(10);
    keys = '0;
    end_scenario("ignored_key");
    n_checks++;
    if (sd_cnt != 10) $display("FAIL ignored_key_scans: got %0d scans, expected 10", sd_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_short_press();
    test_overlap();
    test_two_players();
    test_down_keys();
    test_reset_mid_scan();
    test_ignored_key();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_arbiter.md
KEYPAD_SCAN_ARBITER -- requirements
Module: keypad_scan_arbiter

Interface
REQ-001 SHALL have parameter DEB_SCANS, default 3, giving the number of consecutive identical scans needed to change a key's debounced state (range 1..15).
REQ-002 SHALL have parameter RPT_SCANS, default 5, giving the number of completed scans between repeat steps while a key is held (range 1..15).
REQ-003 clk  input  1  scan clock (100 Hz); all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 kp_col  input  4  keypad column return, active-low.
REQ-006 kp_row  output  4  keypad row drive, one-cold, registered.
REQ-007 up1, down1  output  1 each  player-1 step pulses (keys A / 0), one clk wide, registered.
REQ-008 up2, down2  output  1 each  player-2 step pulses (keys 8 / 7), one clk wide, registered.
REQ-009 scan_done  output  1  one-clk pulse marking the end of each full 4-row scan.

Function
REQ-010 SHALL drive kp_row through 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing one step per clk; any other value SHALL go to 1110.
REQ-011 SHALL sample kp_col on the edge that ends each kp_row step and store it into a 16-bit scan snapshot at bit position {row index, col index}.
REQ-012 SHALL raise scan_done in the clk after the 0111 sample; the snapshot is then complete and the next scan begins at 1110.
REQ-013 Key map: row 1110 col 0 = key 7, row 1110 col 3 = key 0, row 1101 col 0 = key 8, row 1101 col 3 = key A; other keys SHALL be ignored.
REQ-014 Each of the 4 mapped keys SHALL have a debounced state, updated only at scan completion: it SHALL flip after DEB_SCANS consecutive scans whose raw value differs from the current state, and the count SHALL clear on any scan that agrees with the current state.
REQ-015 On a debounced press of a player's key, the matching output SHALL pulse in the clk after the scan completion that set the state; latency is DEB_SCANS scans plus 1 clk from the first pressed sample.
REQ-016 While a key stays debounced-pressed, the matching output SHALL pulse again every RPT_SCANS completed scans after the previous pulse.
REQ-017 If a player's up and down keys are both debounced-pressed, that player's outputs SHALL both stay 0 and that player's repeat counter SHALL hold at 0; when one key is released, the remaining key SHALL pulse at the next scan completion and then repeat.
REQ-018 The two players SHALL be arbitrated independently; simultaneous steps for player 1 and player 2 in the same clk SHALL both be issued.
REQ-019 A debounced release SHALL stop repeats immediately and produce no pulse.
REQ-020 Repeat and debounce counters SHALL saturate rather than wrap.

Reset
REQ-021 While rst=1: kp_row=1110, snapshot=16'hFFFF (all released), all debounce states released, all counters 0, and up1/down1/up2/down2/scan_done=0.
REQ-022 Deasserting rst mid-scan SHALL restart scanning at row 1110, with no partial-scan update and no output pulse.

Structure
REQ-023 Shared package pong_pkg SHALL hold the row drive constants, the key-index constants for A/0/8/7, and the DEB_SCANS/RPT_SCANS defaults.
REQ-024 Per-key debounce SHALL be one sub-module, kp_debounce (raw bit, scan strobe -> debounced state plus press edge), instantiated 4 times.

Verification
REQ-025 Hold A pressed, DEB_SCANS=3, RPT_SCANS=5 -> first up1 pulse 1 clk after the 3rd scan_done, then up1 pulses every 5 scans (every 20 clk); no other outputs pulse.
REQ-026 A pressed for 2 scans, then released -> no up1 pulse ever.
REQ-027 Hold A and 0 together for 10 scans, then release 0 -> no player-1 pulses during overlap, and up1 at the scan completion after 0's debounced release.
REQ-028 Hold A and 8 together -> up1 and up2 pulse in the same clk at every step.
REQ-029 Assert rst for 1 clk mid-scan (kp_row=1011) while A is held -> kp_row=1110 asynchronously, outputs 0, and re-debounce needs 3 full scans before up1.
REQ-030 Drive kp_col=1110 only while kp_row=1011 (key 9) -> no step outputs, and scan_done keeps its 4-clk period.
